// File: rtl/anton_neopixel_apb_packer_pkg.sv
// Shared constants for the NeoPixel APB packer: FSM encoding, window select
// bit, packed burst length and the default pixel-buffer bound.
package anton_neopixel_apb_packer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int          WIN_SEL_BIT        = 16;
    localparam int          PACK_LEN           = 4;
    localparam logic [1:0]  K_LAST             = 2'(PACK_LEN - 1);
    localparam int unsigned BUFFER_END_DEFAULT = 1023;

endpackage

// File: rtl/anton_neopixel_byte_seq.sv
// Byte sequencer: walks k=0..3 over the raw byte bus, muxes the write lane
// and demuxes returned read bytes into the 32-bit read word.
module anton_neopixel_byte_seq
    import anton_neopixel_apb_packer_pkg::*;
(
    input  logic        busClk,
    input  logic        busResetN,
    input  logic        i_start,
    input  logic        i_advance,
    input  logic        i_packed,
    input  logic [13:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_rd_active,
    input  logic [7:0]  i_rbyte,
    output logic [13:0] o_addr,
    output logic [7:0]  o_wbyte,
    output logic        o_last,
    output logic [31:0] o_rdata
);

    logic [1:0]  r_k;
    logic [1:0]  r_cap_k;
    logic        r_cap_en;
    logic [13:0] r_base;
    logic [13:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_wbyte;
    logic [31:0] r_rdata;
    logic [1:0]  w_k_nxt;

    assign w_k_nxt = r_k + 2'd1;

    always_ff @(posedge busClk or negedge busResetN) begin
        if (!busResetN) begin
            r_k      <= 2'd0;
            r_cap_k  <= 2'd0;
            r_cap_en <= 1'b0;
            r_base   <= 14'd0;
            r_addr   <= 14'd0;
            r_wdata  <= 32'd0;
            r_wbyte  <= 8'd0;
            r_rdata  <= 32'd0;
        end else begin
            // Read data returns one cycle after the strobe, so remember its lane.
            r_cap_en <= i_rd_active;
            r_cap_k  <= r_k;
            if (i_start) begin
                r_k     <= 2'd0;
                r_base  <= i_addr;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_wbyte <= i_wdata[7:0];
            end else if (i_advance) begin
                r_k     <= w_k_nxt;
                r_addr  <= r_base + {12'd0, w_k_nxt};
                r_wbyte <= r_wdata[{w_k_nxt, 3'b000} +: 8];
            end
            if (r_cap_en) begin
                if (i_packed) begin
                    r_rdata[{r_cap_k, 3'b000} +: 8] <= i_rbyte;
                end else begin
                    r_rdata <= {24'd0, i_rbyte};
                end
            end
        end
    end

    assign o_addr  = r_addr;
    assign o_wbyte = r_wbyte;
    assign o_last  = (r_k == K_LAST);
    assign o_rdata = r_rdata;

endmodule

// File: rtl/anton_neopixel_apb_packer.sv
// APB3 slave that bridges 32-bit accesses onto the NeoPixel raw byte bus,
// either one byte (direct window) or four little-endian bytes (packed window).
//
// state  | meaning
// IDLE   | waiting for psel&penable
// XFER   | strobing busWrite/busRead, one byte per cycle
// RDWAIT | last read byte in flight from the raw block
// DONE   | pready (and pslverr on a rejected packed access) for one cycle
module anton_neopixel_apb_packer
    import anton_neopixel_apb_packer_pkg::*;
#(
    parameter int unsigned BUFFER_END = BUFFER_END_DEFAULT
) (
    input  logic        busClk,
    input  logic        busResetN,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [16:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut
);

    localparam logic [15:0] LP_END = BUFFER_END[15:0];

    logic [1:0]  r_state;
    logic        r_packed;
    logic        r_write;
    logic        r_bus_write;
    logic        r_bus_read;
    logic        r_pready;
    logic        r_pslverr;

    logic        w_req;
    logic        w_win_pk;
    logic        w_pk_err;
    logic        w_start;
    logic        w_advance;
    logic        w_last;
    logic [13:0] w_pk_base;
    logic [13:0] w_start_addr;
    logic [15:0] w_pk_top;
    logic        w_unused_addr;

    assign w_req        = (r_state == ST_IDLE) && psel && penable;
    assign w_win_pk     = paddr[WIN_SEL_BIT];
    assign w_pk_base    = {1'b0, paddr[12:2], 2'b00};
    assign w_pk_top     = {2'b00, w_pk_base} + 16'(PACK_LEN - 1);
    assign w_pk_err     = (paddr[15:13] != 3'b000) || (w_pk_top > LP_END);
    assign w_start      = w_req && !(w_win_pk && w_pk_err);
    assign w_advance    = (r_state == ST_XFER) && r_packed && !w_last;
    assign w_start_addr = w_win_pk ? w_pk_base : paddr[15:2];
    assign w_unused_addr = ^paddr[1:0];

    always_ff @(posedge busClk or negedge busResetN) begin
        if (!busResetN) begin
            r_state     <= ST_IDLE;
            r_packed    <= 1'b0;
            r_write     <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_read  <= 1'b0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_packed <= w_win_pk;
                        r_write  <= pwrite;
                        if (w_start) begin
                            r_state     <= ST_XFER;
                            r_bus_write <= pwrite;
                            r_bus_read  <= !pwrite;
                        end else begin
                            r_state   <= ST_DONE;
                            r_pready  <= 1'b1;
                            r_pslverr <= 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    if (!r_packed || w_last) begin
                        r_bus_write <= 1'b0;
                        r_bus_read  <= 1'b0;
                        if (r_write) begin
                            r_state  <= ST_DONE;
                            r_pready <= 1'b1;
                        end else begin
                            r_state <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    r_state  <= ST_DONE;
                    r_pready <= 1'b1;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    anton_neopixel_byte_seq u_byte_seq (
        .busClk      (busClk),
        .busResetN   (busResetN),
        .i_start     (w_start),
        .i_advance   (w_advance),
        .i_packed    (r_packed),
        .i_addr      (w_start_addr),
        .i_wdata     (pwdata),
        .i_rd_active (r_bus_read),
        .i_rbyte     (busDataOut),
        .o_addr      (busAddr),
        .o_wbyte     (busDataIn),
        .o_last      (w_last),
        .o_rdata     (prdata)
    );

    assign busWrite = r_bus_write;
    assign busRead  = r_bus_read;
    assign pready   = r_pready;
    assign pslverr  = r_pslverr;

endmodule

// File: tb/tb_anton_neopixel_apb_packer.sv
// Self-checking bench for the NeoPixel APB packer with a raw byte-bus memory
// model and queue-based scoreboard of expected strobes and read data.
module tb_anton_neopixel_apb_packer;

    logic        busClk    = 1'b0;
    logic        busResetN = 1'b1;
    logic        psel      = 1'b0;
    logic        penable   = 1'b0;
    logic        pwrite    = 1'b0;
    logic [16:0] paddr     = 17'd0;
    logic [31:0] pwdata    = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut = 8'd0;

    logic [7:0]  mem [0:16383];
    logic [21:0] wq [$];
    logic [13:0] rq [$];
    logic [31:0] dq [$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_wr  = 0;
    int          n_rd  = 0;

    anton_neopixel_apb_packer #(.BUFFER_END(15)) dut (
        .busClk     (busClk),
        .busResetN  (busResetN),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .busAddr    (busAddr),
        .busDataIn  (busDataIn),
        .busWrite   (busWrite),
        .busRead    (busRead),
        .busDataOut (busDataOut)
    );

    always #5 busClk = ~busClk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Raw pixel block: writes land on the edge, read data is registered.
    always @(posedge busClk) begin
        if (busWrite) mem[busAddr] <= busDataIn;
        busDataOut <= (busAddr == 14'h2000) ? 8'h07 : mem[busAddr];
    end

    always @(negedge busClk) begin
        if (busWrite) begin
            n_wr++;
            chk("wr_vs_rd", 32'(busRead), 32'd0);
            if (wq.size() == 0) begin
                chk("wr_unexp", 32'(wq.size()), 32'd1);
            end else begin
                logic [21:0] e;
                e = wq.pop_front();
                chk("wr_addr", 32'(busAddr), 32'(e[21:8]));
                chk("wr_data", 32'(busDataIn), 32'(e[7:0]));
            end
        end
        if (busRead) begin
            n_rd++;
            if (rq.size() == 0) begin
                chk("rd_unexp", 32'(rq.size()), 32'd1);
            end else begin
                chk("rd_addr", 32'(busAddr), 32'(rq.pop_front()));
            end
        end
    end

    task automatic apb(input string tag, input logic [16:0] a, input logic wr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input bit hold_prev, input bit hold_next);
        int          wr0;
        int          rd0;
        int          lat;
        int          nstb;
        logic [13:0] base;
        base = a[16] ? {a[13:2], 2'b00} : a[15:2];
        nstb = exp_err ? 0 : (a[16] ? 4 : 1);
        for (int k = 0; k < nstb; k++) begin
            if (wr) wq.push_back({base + 14'(k), wd[8*k +: 8]});
            else    rq.push_back(base + 14'(k));
        end
        if (!wr) dq.push_back(exp_rd);
        wr0 = n_wr;
        rd0 = n_rd;
        if (hold_prev) begin
            paddr = a; pwrite = wr; pwdata = wd;
            @(posedge busClk);
        end else begin
            @(negedge busClk);
            paddr = a; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
            @(negedge busClk);
            penable = 1'b1;
        end
        @(posedge busClk);
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge busClk);
            if (pready) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (lat != 0) begin
            chk({tag, "_err"}, 32'(pslverr), 32'(exp_err));
            if (!wr) chk({tag, "_rdata"}, prdata, dq.pop_front());
        end else if (!wr) begin
            void'(dq.pop_front());
        end
        chk({tag, "_nwr"}, 32'(n_wr - wr0), wr ? 32'(nstb) : 32'd0);
        chk({tag, "_nrd"}, 32'(n_rd - rd0), wr ? 32'd0 : 32'(nstb));
        if (!hold_next) begin
            psel = 1'b0;
            penable = 1'b0;
            @(negedge busClk);
            chk({tag, "_drop"}, 32'(pready), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 busResetN = 1'b0;
        #4;
        chk("rst_wr",    32'(busWrite),  32'd0);
        chk("rst_rd",    32'(busRead),   32'd0);
        chk("rst_rdy",   32'(pready),    32'd0);
        chk("rst_err",   32'(pslverr),   32'd0);
        chk("rst_addr",  32'(busAddr),   32'd0);
        chk("rst_din",   32'(busDataIn), 32'd0);
        chk("rst_rdata", prdata,         32'd0);
        repeat (2) @(negedge busClk);
        busResetN = 1'b1;

        apb("dwr",      17'h00010, 1'b1, 32'h000000A5, 32'h0,        1'b0, 2, 1'b0, 1'b0);
        apb("pwr",      17'h10008, 1'b1, 32'h44332211, 32'h0,        1'b0, 5, 1'b0, 1'b0);
        apb("prd",      17'h10008, 1'b0, 32'h0,        32'h44332211, 1'b0, 6, 1'b0, 1'b0);
        apb("drd",      17'h08000, 1'b0, 32'h0,        32'h00000007, 1'b0, 3, 1'b0, 1'b0);
        apb("dwr_hi",   17'h0FFFC, 1'b1, 32'hFFFFFF5A, 32'h0,        1'b0, 2, 1'b0, 1'b0);
        apb("pwr_bnd",  17'h1000C, 1'b1, 32'hDDCCBBAA, 32'h0,        1'b0, 5, 1'b0, 1'b0);
        apb("prd_bnd",  17'h1000C, 1'b0, 32'h0,        32'hDDCCBBAA, 1'b0, 6, 1'b0, 1'b0);
        apb("drd_hi",   17'h0FFFC, 1'b0, 32'h0,        32'h0000005A, 1'b0, 3, 1'b0, 1'b0);
        apb("pwr_oob",  17'h10010, 1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 1, 1'b0, 1'b0);
        apb("prd_oob",  17'h10010, 1'b0, 32'h0,        32'h0000005A, 1'b1, 1, 1'b0, 1'b0);
        apb("prd_hia",  17'h12000, 1'b0, 32'h0,        32'h0000005A, 1'b1, 1, 1'b0, 1'b0);
        apb("pwr_hia",  17'h1E008, 1'b1, 32'h12345678, 32'h0,        1'b1, 1, 1'b0, 1'b0);
        apb("b2b_pwr",  17'h10000, 1'b1, 32'h04030201, 32'h0,        1'b0, 5, 1'b0, 1'b1);
        apb("b2b_drd",  17'h00004, 1'b0, 32'h0,        32'h00000002, 1'b0, 3, 1'b1, 1'b0);

        // Reset lands in E+2 of a packed write: only bytes 0 and 1 may appear.
        wq.push_back({14'd12, 8'h33});
        wq.push_back({14'd13, 8'h44});
        @(negedge busClk);
        paddr = 17'h1000C; pwrite = 1'b1; pwdata = 32'h66554433; psel = 1'b1; penable = 1'b0;
        @(negedge busClk);
        penable = 1'b1;
        @(posedge busClk);
        @(negedge busClk);
        @(negedge busClk);
        #1 busResetN = 1'b0;
        #1;
        chk("mrst_wr",    32'(busWrite),  32'd0);
        chk("mrst_addr",  32'(busAddr),   32'd0);
        chk("mrst_din",   32'(busDataIn), 32'd0);
        chk("mrst_rdata", prdata,         32'd0);
        psel = 1'b0;
        penable = 1'b0;
        repeat (3) begin
            @(negedge busClk);
            chk("mrst_rdy", 32'(pready), 32'd0);
        end
        busResetN = 1'b1;
        chk("mrst_wq", 32'(wq.size()), 32'd0);

        apb("prd_rst",  17'h10008, 1'b0, 32'h0,        32'h44332211, 1'b0, 6, 1'b0, 1'b0);
        repeat (4) @(negedge busClk);
        chk("end_wq", 32'(wq.size()), 32'd0);
        chk("end_rq", 32'(rq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
